// File: rtl/uart_tx_frame.sv
// UART transmitter: serialises one byte per synchronised button press at a
// lockable, switch-selected baud rate (8 data bits, optional parity, 1/2 stops).
//
// state     | meaning
// ----------+---------------------------------------------
// ST_IDLE   | line idle high, waiting for a start
// ST_START  | start bit (low) for one bit period
// ST_DATA   | data bits, LSB first, idx_q selects the bit
// ST_PARITY | parity bit (only reachable when PARITY_EN=1)
// ST_STOP   | stop bit(s) high; done on the final cycle
module uart_tx_frame #(
    parameter int CLK_FREQ   = 100000000,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       src_clk,
    input  logic       rst_n,
    input  logic [1:0] baud_sel,
    input  logic       baud_lock,
    input  logic [7:0] tx_data,
    input  logic       send_item,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int DIV_MAX = CLK_FREQ / 9600;
    // Sized for the longest single period: two stop bits at the slowest rate.
    localparam int CW = $clog2(2 * DIV_MAX + 1);

    localparam logic [CW-1:0] DIV_9600   = CW'(CLK_FREQ / 9600);
    localparam logic [CW-1:0] DIV_57600  = CW'(CLK_FREQ / 57600);
    localparam logic [CW-1:0] DIV_115200 = CW'(CLK_FREQ / 115200);
    localparam logic [CW-1:0] DIV_230400 = CW'(CLK_FREQ / 230400);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [1:0]    baud_q, baud_d;
    logic          sync1_q, sync2_q, edge_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] div_q, div_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    data_q, data_d;
    logic          par_q, par_d;
    logic          tx_q, tx_d;
    logic [CW-1:0] div_sel;
    logic [CW-1:0] stop_len;
    logic          start;

    always_ff @(posedge src_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            baud_q  <= 2'b01;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            edge_q  <= 1'b0;
            cnt_q   <= '0;
            div_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            sync1_q <= send_item;
            sync2_q <= sync1_q;
            edge_q  <= sync2_q;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        case (baud_q)
            2'b00:   div_sel = DIV_9600;
            2'b01:   div_sel = DIV_57600;
            2'b10:   div_sel = DIV_115200;
            default: div_sel = DIV_230400;
        endcase
    end

    // div_q never uses its top bit, so doubling cannot overflow.
    assign stop_len = (STOP_BITS == 2) ? {div_q[CW-2:0], 1'b0} : div_q;
    assign start    = sync2_q & ~edge_q;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        idx_d   = idx_q;
        data_d  = data_q;
        par_d   = par_q;
        tx_d    = tx_q;

        if (state_q == ST_IDLE && !baud_lock) begin
            baud_d = baud_sel;
        end

        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (start) begin
                    state_d = ST_START;
                    div_d   = div_sel;
                    cnt_d   = div_sel - CW'(1);
                    data_d  = tx_data;
                    par_d   = (^tx_data) ^ (PARITY_ODD != 0);
                    tx_d    = 1'b0;
                end
            end
            ST_START: begin
                if (cnt_q == '0) begin
                    state_d = ST_DATA;
                    idx_d   = 3'd0;
                    cnt_d   = div_q - CW'(1);
                    tx_d    = data_q[0];
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (idx_q != 3'd7) begin
                    idx_d = idx_q + 3'd1;
                    cnt_d = div_q - CW'(1);
                    tx_d  = data_q[idx_q + 3'd1];
                end else if (PARITY_EN != 0) begin
                    state_d = ST_PARITY;
                    cnt_d   = div_q - CW'(1);
                    tx_d    = par_q;
                end else begin
                    state_d = ST_STOP;
                    cnt_d   = stop_len - CW'(1);
                    tx_d    = 1'b1;
                end
            end
            ST_PARITY: begin
                if (cnt_q == '0) begin
                    state_d = ST_STOP;
                    cnt_d   = stop_len - CW'(1);
                    tx_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_STOP: begin
                tx_d = 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign tx   = tx_q;
    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_STOP) && (cnt_q == '0);

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: three parameter variants driven by shared stimulus,
// checked every cycle against a frame-level model plus hand-computed literals.
module tb_uart_tx_frame;

    localparam int CLK_FREQ = 10000000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] baud_sel = 2'b01;
    logic       baud_lock = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       send_item = 1'b0;
    logic [2:0] tx_w, busy_w, done_w;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_frame #(.CLK_FREQ(CLK_FREQ), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
        .src_clk(clk), .rst_n(rst_n), .baud_sel(baud_sel), .baud_lock(baud_lock),
        .tx_data(tx_data), .send_item(send_item),
        .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));

    uart_tx_frame #(.CLK_FREQ(CLK_FREQ), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u1 (
        .src_clk(clk), .rst_n(rst_n), .baud_sel(baud_sel), .baud_lock(baud_lock),
        .tx_data(tx_data), .send_item(send_item),
        .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));

    uart_tx_frame #(.CLK_FREQ(CLK_FREQ), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u2 (
        .src_clk(clk), .rst_n(rst_n), .baud_sel(baud_sel), .baud_lock(baud_lock),
        .tx_data(tx_data), .send_item(send_item),
        .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]));

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    int   m_pen [3] = '{0, 1, 1};
    int   m_podd[3] = '{0, 0, 1};
    int   m_sb  [3] = '{1, 2, 2};
    int   ecount;
    logic h1, h2, h3;
    int   fs[3], fdiv[3], flen[3];
    logic fbits[3][12];
    logic [1:0] mbaud[3];
    logic exp_tx[3], exp_busy[3], exp_done[3];
    int   m_nb, m_k;
    logic m_idle, m_start;

    function automatic int div_of(input logic [1:0] b);
        case (b)
            2'b00:   return CLK_FREQ / 9600;
            2'b01:   return CLK_FREQ / 57600;
            2'b10:   return CLK_FREQ / 115200;
            default: return CLK_FREQ / 230400;
        endcase
    endfunction

    task automatic model_reset();
        h1 = 0; h2 = 0; h3 = 0;
        for (int i = 0; i < 3; i++) begin
            fs[i] = -1; flen[i] = 0; fdiv[i] = 1;
            mbaud[i] = 2'b01;
            exp_tx[i] = 1'b1; exp_busy[i] = 1'b0; exp_done[i] = 1'b0;
        end
    endtask

    initial begin
        ecount = 0;
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                ecount++;
                // A start reaches the FSM two edges after the press is first sampled.
                m_start = h2 && !h3;
                for (int i = 0; i < 3; i++) begin
                    m_idle = (fs[i] < 0) || (ecount - 1 - fs[i] >= flen[i]);
                    if (m_start && m_idle) begin
                        fs[i] = ecount;
                        fdiv[i] = div_of(mbaud[i]);
                        fbits[i][0] = 1'b0;
                        for (int b = 0; b < 8; b++) fbits[i][1 + b] = tx_data[b];
                        m_nb = 9;
                        if (m_pen[i] != 0) begin
                            fbits[i][m_nb] = (^tx_data) ^ (m_podd[i] != 0);
                            m_nb++;
                        end
                        for (int s = 0; s < m_sb[i]; s++) begin
                            fbits[i][m_nb] = 1'b1;
                            m_nb++;
                        end
                        flen[i] = m_nb * fdiv[i];
                    end
                    if (m_idle && !baud_lock) mbaud[i] = baud_sel;
                    m_k = ecount - fs[i];
                    if (fs[i] >= 0 && m_k < flen[i]) begin
                        exp_tx[i] = fbits[i][m_k / fdiv[i]];
                        exp_busy[i] = 1'b1;
                        exp_done[i] = (m_k == flen[i] - 1);
                    end else begin
                        exp_tx[i] = 1'b1; exp_busy[i] = 1'b0; exp_done[i] = 1'b0;
                    end
                end
                h3 = h2; h2 = h1; h1 = send_item;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("model_tx%0d", i), int'(tx_w[i]), int'(exp_tx[i]));
            chk($sformatf("model_busy%0d", i), int'(busy_w[i]), int'(exp_busy[i]));
            chk($sformatf("model_done%0d", i), int'(done_w[i]), int'(exp_done[i]));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic press(input int n);
        send_item = 1'b1;
        tick(n);
        send_item = 1'b0;
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while (busy_w != 3'b000 && c < 30000) begin
            tick(1);
            c++;
        end
        chk("idle_timeout", int'(c < 30000), 1);
        tick(2);
    endtask

    task automatic measure_busy(input int i, output int len);
        int c;
        c = 0;
        len = 0;
        while (!busy_w[i] && c < 100) begin
            tick(1);
            c++;
        end
        while (busy_w[i] && len < 20000) begin
            tick(1);
            len++;
        end
    endtask

    int exp_a5[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    int exp_len[4] = '{10410, 1730, 860, 430};
    int len, cur, rises;
    logic prev;

    initial begin
        tick(3);
        chk("rst_tx", int'(tx_w), 7);
        chk("rst_busy", int'(busy_w), 0);
        chk("rst_done", int'(done_w), 0);
        rst_n = 1'b1;
        tick(3);

        // A5 at 57600 (DIV 173): latency and bit-centre values.
        tx_data = 8'hA5;
        send_item = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("lat_edge2_tx", int'(tx_w[0]), 1);
        @(posedge clk); #1;
        chk("lat_edge3_tx", int'(tx_w[0]), 0);
        chk("lat_edge3_busy", int'(busy_w[0]), 1);
        send_item = 1'b0;
        cur = 0;
        for (int b = 0; b < 10; b++) begin
            repeat (b * 173 + 86 - cur) @(posedge clk);
            #1;
            cur = b * 173 + 86;
            chk($sformatf("a5_bit%0d", b), int'(tx_w[0]), exp_a5[b]);
        end
        repeat (1728 - cur) @(posedge clk);
        #1;
        chk("a5_done_early", int'(done_w[0]), 0);
        @(posedge clk); #1;
        chk("a5_done", int'(done_w[0]), 1);
        @(posedge clk); #1;
        chk("a5_busy_after", int'(busy_w[0]), 0);
        tick(1);
        wait_idle();

        // Baud sweep with 0x55.
        for (int b = 0; b < 4; b++) begin
            baud_sel = 2'(b);
            tx_data = 8'h55;
            tick(3);
            press(2);
            measure_busy(0, len);
            chk($sformatf("sweep_len%0d", b), len, exp_len[b]);
            wait_idle();
        end

        // Baud lock holds 57600 while baud_sel moves.
        baud_sel = 2'b01;
        tick(2);
        baud_lock = 1'b1;
        tick(1);
        baud_sel = 2'b00; tick(5);
        baud_sel = 2'b10; tick(5);
        baud_sel = 2'b11; tick(5);
        tx_data = 8'h0F;
        press(2);
        measure_busy(0, len);
        chk("lock_len", len, 1730);
        wait_idle();
        baud_sel = 2'b10;
        baud_lock = 1'b0;
        tick(3);
        press(2);
        measure_busy(0, len);
        chk("unlock_len", len, 860);
        wait_idle();

        // Held button gives one frame.
        rises = 0;
        prev = busy_w[0];
        send_item = 1'b1;
        for (int t = 0; t < 8000; t++) begin
            tick(1);
            if (busy_w[0] && !prev) rises++;
            prev = busy_w[0];
        end
        send_item = 1'b0;
        chk("hold_frames", rises, 1);
        wait_idle();

        // Second press while busy is dropped.
        rises = 0;
        prev = busy_w[0];
        for (int t = 0; t < 2000; t++) begin
            send_item = (t < 3) || (t >= 300 && t < 303);
            tick(1);
            if (busy_w[0] && !prev) rises++;
            prev = busy_w[0];
        end
        send_item = 1'b0;
        chk("busy_press_frames", rises, 1);
        wait_idle();

        // Back-to-back at 230400 (DIV 43): next start lands as IDLE is re-entered.
        baud_sel = 2'b11;
        tick(3);
        send_item = 1'b1;
        tick(3);
        send_item = 1'b0;
        tick(428);
        send_item = 1'b1;
        tick(1);
        chk("b2b_done", int'(done_w[0]), 1);
        chk("b2b_busy_end", int'(busy_w[0]), 1);
        tick(1);
        chk("b2b_gap", int'(busy_w[0]), 0);
        tick(1);
        chk("b2b_restart_busy", int'(busy_w[0]), 1);
        chk("b2b_restart_tx", int'(tx_w[0]), 0);
        send_item = 1'b0;
        wait_idle();

        // Parity on 0x07 at 115200 (DIV 86).
        baud_sel = 2'b10;
        tx_data = 8'h07;
        tick(3);
        send_item = 1'b1;
        tick(3);
        send_item = 1'b0;
        tick(9 * 86 + 43);
        chk("parity_even", int'(tx_w[1]), 1);
        chk("parity_odd", int'(tx_w[2]), 0);
        wait_idle();
        press(2);
        measure_busy(1, len);
        chk("parity_len", len, 1032);
        wait_idle();

        // Reset during data bit 3; baud returns to 57600.
        baud_sel = 2'b10;
        tx_data = 8'hA5;
        tick(3);
        send_item = 1'b1;
        tick(3);
        send_item = 1'b0;
        tick(4 * 86 + 40);
        rst_n = 1'b0;
        #1;
        chk("midrst_tx", int'(tx_w), 7);
        chk("midrst_busy", int'(busy_w), 0);
        baud_lock = 1'b1;
        baud_sel = 2'b11;
        tick(2);
        rst_n = 1'b1;
        tick(20);
        chk("postrst_tx", int'(tx_w), 7);
        chk("postrst_busy", int'(busy_w), 0);
        press(2);
        measure_busy(0, len);
        chk("postrst_len", len, 1730);
        wait_idle();
        baud_lock = 1'b0;

        // Randomised frames, overlapping presses and occasional resets.
        for (int n = 0; n < 14; n++) begin
            baud_sel = 2'($urandom_range(3, 2));
            baud_lock = ($urandom_range(3, 0) == 0);
            tx_data = 8'($urandom);
            press($urandom_range(4, 1));
            tick($urandom_range(600, 0));
            if ($urandom_range(7, 0) == 0) begin
                send_item = $urandom_range(1, 0) != 0;
                rst_n = 1'b0;
                tick($urandom_range(3, 1));
                rst_n = 1'b1;
                tick(4);
                send_item = 1'b0;
            end
        end
        baud_lock = 1'b0;
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
